// File: rtl/lab00_debounce.sv
// ---------------------------------------------------------------------------
// lab00_debounce
//
// Turns a raw, asynchronous and bouncy button/switch level into a clean
// level plus one-cycle edge pulses. The clean level drives the lab00 inverter.
//
// Parameters
//   STABLE_CYCLES : number of consecutive cycles the synchronized input must
//                   disagree with o_y before o_y follows it (1..2^CNT_W-1)
//   CNT_W         : width of the stability counter
//
// Ports
//   i_clk   : sole clock, all state changes on its rising edge
//   i_rst   : synchronous active-high reset
//   i_x     : raw asynchronous level
//   o_y     : debounced level (registered)
//   o_rise  : one-cycle pulse after o_y goes 0->1 (registered)
//   o_fall  : one-cycle pulse after o_y goes 1->0 (registered)
//   o_count : number of rising events since reset, modulo 256 (registered)
// ---------------------------------------------------------------------------
module lab00_debounce #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_x,
    output logic       o_y,
    output logic       o_rise,
    output logic       o_fall,
    output logic [7:0] o_count
);

    // Terminal count: the mismatch has lasted STABLE_CYCLES cycles when the
    // counter already holds STABLE_CYCLES-1 and still sees a mismatch.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;
    logic             y_r;
    logic             rise_r;
    logic             fall_r;
    logic [7:0]       count_r;

    logic             mismatch_s;
    logic             load_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Stability counter next-state and output-load decision.
    always_comb begin
        mismatch_s = sync2_r ^ y_r;
        load_s     = 1'b0;
        cnt_nxt_s  = {CNT_W{1'b0}};
        if (!mismatch_s) begin
            // Any agreeing cycle restarts the stability window.
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            load_s    = 1'b1;
            cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Synchronizer, counter, debounced level, edge pulses and rise counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            y_r     <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            count_r <= 8'd0;
        end else begin
            sync1_r <= i_x;
            sync2_r <= sync1_r;
            cnt_r   <= cnt_nxt_s;
            // A load always flips y_r, so the new value (sync2_r) tells the
            // direction of the edge.
            rise_r  <= load_s & sync2_r;
            fall_r  <= load_s & ~sync2_r;
            if (load_s) begin
                y_r <= sync2_r;
            end else begin
                y_r <= y_r;
            end
            if (load_s && sync2_r) begin
                count_r <= count_r + 8'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign o_y     = y_r;
    assign o_rise  = rise_r;
    assign o_fall  = fall_r;
    assign o_count = count_r;

endmodule

// File: doc/lab00_debounce.md
LAB00_DEBOUNCE -- requirements
Module: lab00_debounce

Upstream conditioning stage: turns a raw, asynchronous, bouncy switch or button level into a clean level and edge pulses. The clean level feeds the lab00 inverter input.

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: number of consecutive cycles a synchronized input must differ from the output before the output follows it; legal range 1..2^CNT_W-1.
REQ-002 Parameter CNT_W, default 4: width of the stability counter.
REQ-003 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_x  input  1  raw asynchronous level (button/switch).
REQ-006 o_y  output  1  debounced level, registered.
REQ-007 o_rise  output  1  one-cycle pulse when o_y goes 0->1, registered.
REQ-008 o_fall  output  1  one-cycle pulse when o_y goes 1->0, registered.
REQ-009 o_count  output  8  number of o_rise events since reset, modulo 256.

Function
REQ-010 i_x shall pass through a 2-flop synchronizer (s1, s2) before any other use; no logic shall read i_x directly.
REQ-011 Stability counter cnt (CNT_W bits) shall clear to 0 in any cycle where s2 == o_y.
REQ-012 In a cycle where s2 != o_y and cnt < STABLE_CYCLES-1, cnt shall increment by 1.
REQ-013 In a cycle where s2 != o_y and cnt == STABLE_CYCLES-1, o_y shall load s2 and cnt shall clear to 0 on the same edge.
REQ-014 Latency: if i_x takes a new value before edge k and holds it, o_y shall take that value at edge k+1+STABLE_CYCLES, exactly.
REQ-015 Glitch rejection: any s2 mismatch lasting fewer than STABLE_CYCLES consecutive cycles shall leave o_y unchanged; a single matching cycle restarts the count from 0.
REQ-016 o_rise shall be 1 for exactly the cycle following the edge where o_y changes 0->1, and 0 otherwise.
REQ-017 o_fall shall be 1 for exactly the cycle following the edge where o_y changes 1->0, and 0 otherwise.
REQ-018 o_rise and o_fall shall never be 1 simultaneously; two consecutive pulses shall be at least STABLE_CYCLES cycles apart.
REQ-019 o_count shall increment by 1 on the same edge that asserts o_rise, and wrap from 255 to 0 with no flag.
REQ-020 STABLE_CYCLES == 1: o_y shall follow s2 with one cycle of delay, and REQ-014 shall still hold (edge k+2).
REQ-021 cnt shall never exceed STABLE_CYCLES-1.

Reset
REQ-022 While i_rst is 1 at a clock edge: s1, s2, cnt, o_y, o_rise, o_fall and o_count shall all become 0.
REQ-023 Reset shall take priority over every other update, including a pending o_y change in the same cycle.
REQ-024 After reset is released with i_x == 1, o_y shall rise at edge STABLE_CYCLES+2 after release, with a normal o_rise pulse and o_count = 1.
REQ-025 Before the first clock edge with i_rst high, outputs are undefined; the bench shall hold i_rst for at least 2 cycles.

Verification (STABLE_CYCLES=4)
REQ-026 Reset 2 cycles with i_x=0 -> o_y=0, o_rise=0, o_fall=0, o_count=0.
REQ-027 i_x 0->1 before edge k, held -> o_y=1 at edge k+5; o_rise=1 for one cycle; o_count=1.
REQ-028 i_x pulses 1 for 3 cycles, then 0 -> o_y stays 0, no pulses, o_count unchanged.
REQ-029 i_x=1 held, i_rst pulsed for 1 cycle at cnt=2 -> all outputs 0; o_y=1 reached 6 edges after release; o_count=1.
REQ-030 256 clean press/release cycles -> o_count returns to 0; 256 o_rise and 256 o_fall pulses, never overlapping.
REQ-031 i_x toggles every cycle for 20 cycles -> o_y constant, cnt never reaches 4, no pulses.
